board_mem_responder: RTL
========================

Name: board_mem_responder

Overview:
Avalon-MM slave that answers the SDRAM-facing master port of the move-generator accelerators (pawn and siblings). Holds board words in on-chip RAM and serves fixed-latency pipelined reads and single-cycle writes, with waitrequest back-pressure and readdatavalid returns. Used as the board store for on-chip builds and as the memory-side model in accelerator benches.

Parameters:
NUM_WORDS, 1024, 32-bit words of storage (16 boards x 64 squares); power of two
BASE_ADDR, 32'h0000_0000, byte address of word 0; 4-byte aligned
READ_LATENCY, 2, cycles from read acceptance to readdatavalid; range 1..8
MAX_PENDING, 2, maximum reads accepted but not yet returned; range 1..READ_LATENCY

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
slave_waitrequest  out  1  request stall
slave_address  in  32  byte address
slave_read  in  1  read request
slave_readdata  out  32  read data, valid only with readdatavalid
slave_readdatavalid  out  1  one-cycle read return strobe
slave_write  in  1  write request
slave_writedata  in  32  write data
err_count  out  16  saturating count of protocol/decode errors

Behaviour:
- Reset and clock: reset rst_n, synchronous, active-low; clock clk. On reset: slave_readdatavalid=0, slave_readdata=0, err_count=0, pending count=0, all in-flight reads discarded (no readdatavalid after reset, even mid-pipeline). RAM contents are not cleared.
- slave_waitrequest is combinational: high iff pending==MAX_PENDING, plus injection when enabled. It is 0 out of reset.
- Acceptance: a request is accepted in a cycle with (slave_read|slave_write) && !slave_waitrequest.
- Address decode: offset=address-BASE_ADDR (32-bit unsigned). In window iff address>=BASE_ADDR && offset<NUM_WORDS*4. Word index=offset[31:2]. If address[1:0]!=0, low bits are ignored, the access still proceeds on the word index, and err_count increments.
- Accepted write, in window: RAM[word] is written at the end of the accept cycle. No readdatavalid is produced.
- Accepted write, out of window: dropped; err_count increments.
- Accepted read: data is sampled at acceptance (RAM[word], or 32'hFFFF_FFFF if out of window, which also increments err_count). The result enters a READ_LATENCY-deep shift pipeline. A read accepted in cycle T gives slave_readdatavalid=1 with the data in cycle T+READ_LATENCY, for exactly one cycle.
- Returns are strictly in order. The pipeline never stalls because Avalon readdatavalid has no back-pressure.
- Ordering: a write accepted in cycle T is visible to reads accepted in T+1 and later. A read accepted before the write returns old data.
- slave_read && slave_write in the same accept cycle: treated as a write only, no read return, err_count increments.
- Pending count: +1 on read accept, -1 on readdatavalid. Both in the same cycle leave it unchanged. It never exceeds MAX_PENDING.
- While waitrequest=1: no accept occurs, the master must hold its request, and the pipeline continues to drain.
- err_count: +1 per error event, at most +1 per cycle, saturates at 16'hFFFF.
- slave_readdata holds its last value when readdatavalid=0.

Optional Feature:
BOARD_MEM_WAIT_INJECT_EN:
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances every cycle. slave_waitrequest is additionally forced high in any cycle where lfsr[1:0]==2'b00. This stresses the master's hold-while-waitrequest logic. Latency and ordering are unchanged for accepted reads.
- Not defined: waitrequest comes only from the pending limit, and no LFSR exists.

Test Plan:
- Write 32'h0000_0005 to BASE_ADDR+4*9, then read the same address one cycle later (defaults) -> readdatavalid exactly 2 cycles after acceptance, readdata=32'h0000_0005, err_count=0.
- Back-to-back reads of words 0,1,2,3 preloaded with 1,2,3,4 (MAX_PENDING=2, READ_LATENCY=2) -> no waitrequest and readdatavalid every cycle in order 1,2,3,4. With MAX_PENDING=1, waitrequest is high on alternate cycles and returns come in the same order.
- Read at BASE_ADDR+NUM_WORDS*4 -> readdata=32'hFFFF_FFFF after READ_LATENCY, err_count=1. Write to the same address -> RAM unchanged, err_count=2.
- Read word 7 (old value 32'hFFFF_FFFE) at T, write 32'h3 to word 7 at T+1, read word 7 at T+2 -> returns 32'hFFFF_FFFE then 32'h3.
- Issue two reads, assert rst_n=0 for one cycle before their return -> no readdatavalid afterwards, pending=0, waitrequest=0, err_count=0. A previously written word still reads back intact.
- Drive the pawn accelerator's master port against this block (with BOARD_MEM_WAIT_INJECT_EN defined) using a preset board with a white pawn at (3,1) -> the dest-board region contains the expected move boards, and no read is lost or duplicated.

Source files
------------

// File: rtl/board_mem_responder.sv
// board_mem_responder
// Avalon-MM slave holding board words in on-chip RAM. Reads are sampled at
// acceptance and returned through a fixed-latency, non-stalling shift
// pipeline. Writes complete in the accept cycle. Decode, alignment and
// read+write collisions are tallied in a saturating error counter.
//
// Optional build macro: BOARD_MEM_WAIT_INJECT_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//   forces waitrequest high whenever its two low bits are 2'b00.
//
// A pending slot is freed in the cycle its data is returned. This allows a
// fully pipelined master to issue a read every cycle when MAX_PENDING equals
// READ_LATENCY.
module board_mem_responder #(
  parameter int unsigned NUM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_PENDING  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [15:0] err_count
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned PW = $clog2(MAX_PENDING + 1);
  localparam logic [31:0] WINDOW_BYTES = 32'(NUM_WORDS * 4);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  // Storage, not cleared by reset
  logic [31:0] mem [NUM_WORDS];

  // Read return pipeline; the last stage drives the bus outputs
  logic [READ_LATENCY-1:0] vld_r;
  logic [31:0]             dat_r [READ_LATENCY];

  logic [PW-1:0] pending_r;
  logic [15:0]   err_count_r;

  logic [31:0]   offset_s;
  logic          in_window_s;
  logic [AW-1:0] word_idx_s;
  logic          misalign_s;
  logic [PW-1:0] pending_eff_s;
  logic          inject_s;
  logic          wait_s;
  logic          accept_s;
  logic          acc_read_s;
  logic          acc_write_s;
  logic          err_evt_s;
  logic [31:0]   read_word_s;

`ifdef BOARD_MEM_WAIT_INJECT_EN
  logic [15:0] lfsr_r;
  logic        lfsr_fb_s;

  assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  assign inject_s  = (lfsr_r[1:0] == 2'b00);

  // Free-running stall-injection LFSR
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
    end
  end
`else
  assign inject_s = 1'b0;
`endif

  // Address decode, back-pressure and accept qualification
  always_comb begin
    offset_s      = slave_address - BASE_ADDR;
    in_window_s   = (slave_address >= BASE_ADDR) && (offset_s < WINDOW_BYTES);
    word_idx_s    = offset_s[AW+1:2];
    misalign_s    = (slave_address[1:0] != 2'b00);
    // a read returning this cycle no longer occupies a slot
    pending_eff_s = pending_r - PW'(vld_r[READ_LATENCY-1]);
    wait_s        = (pending_eff_s == PEND_MAX) || inject_s;
    accept_s      = (slave_read || slave_write) && !wait_s;
    acc_write_s   = accept_s && slave_write;
    acc_read_s    = accept_s && slave_read && !slave_write;
    err_evt_s     = accept_s && (misalign_s || !in_window_s ||
                                 (slave_read && slave_write));
    if (in_window_s) begin
      read_word_s = mem[word_idx_s];
    end else begin
      read_word_s = 32'hFFFF_FFFF;
    end
  end

  // RAM write port; out-of-window writes are dropped
  always_ff @(posedge clk) begin
    if (acc_write_s && in_window_s) begin
      mem[word_idx_s] <= slave_writedata;
    end
  end

  // Fixed-latency read pipeline; data stages hold when no valid passes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        dat_r[i] <= 32'h0000_0000;
      end
    end else begin
      vld_r[0] <= acc_read_s;
      if (acc_read_s) begin
        dat_r[0] <= read_word_s;
      end
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) begin
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  // Outstanding read count: +1 on read accept, -1 on return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r <= '0;
    end else begin
      case ({acc_read_s, vld_r[READ_LATENCY-1]})
        2'b10:   pending_r <= pending_r + PW'(1);
        2'b01:   pending_r <= pending_r - PW'(1);
        default: pending_r <= pending_r;
      endcase
    end
  end

  // Saturating protocol/decode error counter, at most one step per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_r <= 16'h0000;
    end else if (err_evt_s && (err_count_r != 16'hFFFF)) begin
      err_count_r <= err_count_r + 16'h0001;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign slave_waitrequest   = wait_s;
  assign slave_readdatavalid = vld_r[READ_LATENCY-1];
  assign slave_readdata      = dat_r[READ_LATENCY-1];
  assign err_count           = err_count_r;

endmodule
